// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared widths, one-hot FSM encoding and requester index type for the APB request arbiter
package apb_pkg;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 8;

    // One-hot state encoding, kept as plain constants so older tooling can share it.
    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_ISSUE   = 4'b0010;
    localparam logic [3:0] ST_WAIT    = 4'b0100;
    localparam logic [3:0] ST_RELEASE = 4'b1000;

    // Index of one of the two requesters.
    typedef logic req_idx_t;

endpackage

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - 2-way round-robin selector: requests and priority in, grant index out
module apb_rr_pick
    import apb_pkg::*;
(
    input  logic [1:0] req,          // per-requester pending request
    input  req_idx_t   prio,         // requester that wins a tie
    output logic       grant_valid,  // at least one request pending
    output req_idx_t   grant_idx     // selected requester
);

    always_comb begin
        grant_valid = |req;
        // Priority only matters on a tie; otherwise the single requester wins.
        grant_idx   = (req == 2'b11) ? prio : req[1];
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester APB command arbiter with registered bridge outputs (optional WAIT timeout: APB_ARB_TIMEOUT_EN)
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,  // top address bit selects the slave
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 32           // WAIT cycles before abort, 2..255
) (
    input  logic              PCLK,          // rising-edge clock
    input  logic              PRESETn,       // asynchronous active-low reset
    input  logic [1:0]        req_valid,     // held until the requester's ack
    input  logic [1:0]        req_rw,        // 1 = read, 0 = write
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [1:0]        ack,           // one-cycle completion pulse
    output logic [DATA_W-1:0] rsp_rdata,     // valid with ack
    output logic              rsp_err,       // valid with ack
    output logic              busy,          // high outside IDLE
    output logic              transfer,      // bridge command strobe
    output logic              READ_WRITE,
    output logic [ADDR_W-1:0] write_paddr,
    output logic [ADDR_W-1:0] read_paddr,
    output logic [DATA_W-1:0] write_data,
    input  logic              PENABLE,
    input  logic              PREADY,
    input  logic              PSLVERR,
    input  logic [DATA_W-1:0] bridge_rdata
);

    logic [3:0]        state;
    req_idx_t          prio;
    req_idx_t          winner;

    logic              pick_valid;
    req_idx_t          pick_idx;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              wait_done;
    logic              wait_err;
    logic [DATA_W-1:0] wait_rdata;

    apb_rr_pick u_pick (
        .req         (req_valid),
        .prio        (prio),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    always_comb begin
        sel_rw    = pick_idx ? req_rw[1]  : req_rw[0];
        sel_addr  = pick_idx ? req1_addr  : req0_addr;
        sel_wdata = pick_idx ? req1_wdata : req0_wdata;
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt;
`else
    // Without the timeout the parameter has no consumer.
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT_CYC);
`endif

    // WAIT exit decision; a slave error outranks a simultaneous ready.
    always_comb begin
        wait_done  = 1'b0;
        wait_err   = 1'b0;
        wait_rdata = '0;
        if (PSLVERR) begin
            wait_done = 1'b1;
            wait_err  = 1'b1;
        end else if (PENABLE && PREADY) begin
            wait_done  = 1'b1;
            wait_rdata = READ_WRITE ? bridge_rdata : '0;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (wait_cnt == TO_LAST) begin
            wait_done = 1'b1;
            wait_err  = 1'b1;
        end
`endif
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            prio        <= 1'b0;
            winner      <= 1'b0;
            ack         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            transfer    <= 1'b0;
            READ_WRITE  <= 1'b0;
            write_paddr <= '0;
            read_paddr  <= '0;
            write_data  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        // The command registers double as the frozen copy of the request.
                        state       <= ST_ISSUE;
                        winner      <= pick_idx;
                        prio        <= ~pick_idx;
                        busy        <= 1'b1;
                        transfer    <= 1'b1;
                        READ_WRITE  <= sel_rw;
                        read_paddr  <= sel_rw ? sel_addr : '0;
                        write_paddr <= sel_rw ? '0 : sel_addr;
                        write_data  <= sel_rw ? '0 : sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        state     <= ST_RELEASE;
                        transfer  <= 1'b0;
                        ack       <= winner ? 2'b10 : 2'b01;
                        rsp_err   <= wait_err;
                        rsp_rdata <= wait_rdata;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                ST_RELEASE: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    rsp_err     <= 1'b0;
                    rsp_rdata   <= '0;
                    READ_WRITE  <= 1'b0;
                    read_paddr  <= '0;
                    write_paddr <= '0;
                    write_data  <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    transfer <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter with a round-robin reference model
module tb_apb_req_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [1:0]    req_valid;
    logic [1:0]    req_rw;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic [1:0]    ack;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, busy, transfer, READ_WRITE;
    logic [AW-1:0] write_paddr, read_paddr;
    logic [DW-1:0] write_data;
    logic          PENABLE, PREADY, PSLVERR;
    logic [DW-1:0] bridge_rdata;

    int checks = 0;
    int errors = 0;
    bit prio_m;      // reference: requester that wins the next tie

    apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_rw(req_rw),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .transfer(transfer), .READ_WRITE(READ_WRITE),
        .write_paddr(write_paddr), .read_paddr(read_paddr), .write_data(write_data),
        .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .bridge_rdata(bridge_rdata)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin req0_addr = a; req0_wdata = d; end
        else        begin req1_addr = a; req1_wdata = d; end
        req_rw[r]    = rw;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_issue(output bit ok);
        int n = 0;
        while (transfer !== 1'b1 && n < 20) begin @(negedge PCLK); n++; end
        ok = (n < 20);
    endtask

    // Serves one granted command as the bridge and checks it against the model.
    task automatic serve(input int wait_cyc, input bit slverr, input logic [DW-1:0] rd,
                         input bit early_drop, output int w);
        bit            erw, ok;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (req_valid == 2'b11) w = int'(prio_m);
        else                    w = req_valid[1] ? 1 : 0;
        erw    = req_rw[w];
        ea     = (w == 1) ? req1_addr  : req0_addr;
        ed     = (w == 1) ? req1_wdata : req0_wdata;
        prio_m = (w == 0);
        wait_issue(ok);
        check("grant_seen", 32'(ok), 32'd1);
        check("issue_rw", 32'(READ_WRITE), 32'(erw));
        check("issue_raddr", 32'(read_paddr), erw ? 32'(ea) : 32'd0);
        check("issue_waddr", 32'(write_paddr), erw ? 32'd0 : 32'(ea));
        check("issue_wdata", 32'(write_data), erw ? 32'd0 : 32'(ed));
        check("issue_busy", 32'(busy), 32'd1);
        if (early_drop) req_valid[w] = 1'b0;
        // Disturb the winner's inputs; the latched command must not move.
        if (w == 1) begin req1_addr = AW'($urandom); req1_wdata = DW'($urandom); req_rw[1] = 1'($urandom); end
        else        begin req0_addr = AW'($urandom); req0_wdata = DW'($urandom); req_rw[0] = 1'($urandom); end
        for (int k = 0; k <= wait_cyc; k++) begin
            @(negedge PCLK);
            check("wait_transfer", 32'(transfer), 32'd1);
            check("wait_noack", 32'(ack), 32'd0);
            check("wait_frozen_addr", 32'(erw ? read_paddr : write_paddr), 32'(ea));
            PENABLE      = 1'b1;
            PREADY       = (k == wait_cyc) && !slverr;
            PSLVERR      = (k == wait_cyc) && slverr;
            bridge_rdata = (k == wait_cyc) ? rd : DW'($urandom);
        end
        @(negedge PCLK);
        PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; bridge_rdata = DW'($urandom);
        check("rel_ack", 32'(ack), (w == 1) ? 32'd2 : 32'd1);
        check("rel_err", 32'(rsp_err), 32'(slverr));
        check("rel_rdata", 32'(rsp_rdata), (slverr || !erw) ? 32'd0 : 32'(rd));
        check("rel_transfer", 32'(transfer), 32'd0);
        check("rel_busy", 32'(busy), 32'd1);
        req_valid[w] = 1'b0;
        @(negedge PCLK);
        check("idle_ack_pulse", 32'(ack), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int  w;
        int  n;
        bit  ok, seen;
        int  order[4];

        PRESETn = 1'b0; req_valid = '0; req_rw = '0;
        req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
        PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; bridge_rdata = '0;
        prio_m = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_transfer", 32'(transfer), 32'd0);
        check("rst_cmd", 32'({READ_WRITE, write_paddr, read_paddr, write_data}), 32'd0);
        check("rst_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Write from requester 0, ready immediately.
        set_req(0, 1'b0, 9'h005, 8'hA5);
        serve(0, 1'b0, 8'h00, 1'b0, w);
        check("wr0_winner", 32'(w), 32'd0);

        // Read from requester 1 with three not-ready cycles.
        set_req(1, 1'b1, 9'h105, 8'h00);
        serve(3, 1'b0, 8'h3C, 1'b0, w);
        check("rd1_winner", 32'(w), 32'd1);

        // Two rounds of simultaneous requests.
        for (int r = 0; r < 2; r++) begin
            set_req(0, 1'($urandom), AW'($urandom), DW'($urandom));
            set_req(1, 1'($urandom), AW'($urandom), DW'($urandom));
            serve(1, 1'b0, DW'($urandom), 1'b0, order[2*r]);
            serve(0, 1'b0, DW'($urandom), 1'b0, order[2*r+1]);
        end
        for (int i = 0; i < 4; i++) check("tie_order", 32'(order[i]), 32'(i % 2));

        // Slave error, then a normal command.
        set_req(0, 1'b1, 9'h033, 8'h00);
        serve(2, 1'b1, 8'h77, 1'b0, w);
        set_req(1, 1'b0, 9'h144, 8'h99);
        serve(0, 1'b0, 8'h00, 1'b0, w);

        // Requester withdraws before its ack.
        set_req(0, 1'b1, 9'h0F0, 8'h00);
        serve(1, 1'b0, 8'hE1, 1'b1, w);

        // Randomized traffic; a losing requester stays pending across iterations.
        for (int it = 0; it < 25; it++) begin
            for (int r = 0; r < 2; r++)
                if (!req_valid[r] && ($urandom_range(0, 1) == 1))
                    set_req(r, 1'($urandom), AW'($urandom), DW'($urandom));
            if (req_valid == 2'b00)
                set_req($urandom_range(0, 1), 1'($urandom), AW'($urandom), DW'($urandom));
            serve($urandom_range(0, 4), ($urandom_range(0, 3) == 0), DW'($urandom),
                  ($urandom_range(0, 7) == 0), w);
        end
        n = 0;
        while (req_valid != 2'b00 && n < 4) begin
            serve(0, 1'b0, DW'($urandom), 1'b0, w);
            n++;
        end

        // PREADY never arrives.
        set_req(0, 1'b0, 9'h0AA, 8'h5A);
        wait_issue(ok);
        check("stall_issue", 32'(ok), 32'd1);
        @(negedge PCLK);
        PENABLE = 1'b1; PREADY = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        n = 0;
        while (ack === 2'b00 && n < 20) begin @(negedge PCLK); n++; end
        check("to_latency", 32'(n), 32'd8);
        check("to_ack", 32'(ack), 32'd1);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_rdata", 32'(rsp_rdata), 32'd0);
        req_valid[0] = 1'b0;
        @(negedge PCLK);
        set_req(0, 1'b1, 9'h0BB, 8'h00);
        wait_issue(ok);
        check("rst_issue", 32'(ok), 32'd1);
        @(negedge PCLK);
`else
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (ack !== 2'b00) seen = 1'b1;
        end
        check("no_timeout_ack", 32'(seen), 32'd0);
        check("stall_transfer", 32'(transfer), 32'd1);
`endif
        // Asynchronous reset in WAIT; requester 0 was the last winner.
        #2 PRESETn = 1'b0;
        #1;
        check("async_transfer", 32'(transfer), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ack", 32'(ack), 32'd0);
        PENABLE = 1'b0; req_valid = '0; prio_m = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            if (ack !== 2'b00) seen = 1'b1;
        end
        check("dropped_no_ack", 32'(seen), 32'd0);
        set_req(0, 1'b0, 9'h011, 8'h22);
        set_req(1, 1'b1, 9'h111, 8'h00);
        serve(0, 1'b0, 8'h00, 1'b0, w);
        check("post_rst_prio", 32'(w), 32'd0);
        serve(1, 1'b0, 8'h5C, 1'b0, w);
        check("post_rst_second", 32'(w), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter: ADDR_W, 9, address width; bit ADDR_W-1 selects slave (0 = PSEL1, 1 = PSEL2).
REQ-002 Parameter: DATA_W, 8, data width.
REQ-003 Parameter: TIMEOUT_CYC, 32, maximum WAIT-state cycles before abort (range 2..255).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low. Ports are PCLK and PRESETn.
REQ-005 PCLK  in  1  clock, rising edge.
REQ-006 PRESETn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  2  per-requester request; held high until that requester's ack.
REQ-008 req_rw  in  2  per requester; 1 = read, 0 = write.
REQ-009 req0_addr, req1_addr  in  ADDR_W  target address.
REQ-010 req0_wdata, req1_wdata  in  DATA_W  write data.
REQ-011 ack  out  2  one-cycle completion pulse per requester.
REQ-012 rsp_rdata  out  DATA_W  read data, valid with ack.
REQ-013 rsp_err  out  1  error flag, valid with ack.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 transfer, READ_WRITE  out  1 each  bridge command.
REQ-016 write_paddr, read_paddr  out  ADDR_W  bridge addresses.
REQ-017 write_data  out  DATA_W  bridge write data.
REQ-018 PENABLE, PREADY, PSLVERR  in  1 each  bridge/bus status.
REQ-019 bridge_rdata  in  DATA_W  bridge data_out.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RELEASE. All outputs are registered.
REQ-021 IDLE: if any req_valid is high, the FSM selects a winner round-robin, latches its rw/addr/wdata and goes to ISSUE.
REQ-022 After reset, requester 0 holds priority. Priority rotates to the non-winner after each grant.
REQ-023 ISSUE: transfer=1. READ_WRITE, read_paddr (read), and write_paddr/write_data (write) drive the latched values. The unused address drives 0. The FSM goes to WAIT.
REQ-024 WAIT: completion is a PCLK edge with PENABLE=1 and PREADY=1. On completion, the FSM captures bridge_rdata (read only; otherwise 0) and goes to RELEASE with rsp_err=0.
REQ-025 WAIT: PSLVERR=1 on any edge aborts the transfer. The FSM goes to RELEASE with rsp_err=1 and rsp_rdata=0.
REQ-026 RELEASE: transfer=0 and ack[winner]=1 for exactly one cycle. The FSM then returns to IDLE. Minimum request-to-request spacing is 4 cycles.
REQ-027 Latched command values are frozen from grant until RELEASE. Input changes during this period are ignored.
REQ-028 If a requester deasserts req_valid before its ack, the operation still completes and ack is still pulsed.
REQ-029 If both requesters assert req_valid in the same cycle, only one is granted. The loser waits without any lost request.

Reset
REQ-030 While PRESETn=0, regardless of state: FSM=IDLE, priority=requester 0, and all outputs=0, including transfer.
REQ-031 If reset asserts mid-transfer, the operation is dropped with no ack.

Configuration
REQ-032 The macro APB_ARB_TIMEOUT_EN controls the WAIT-state timeout.
REQ-033 With APB_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT. When it reaches TIMEOUT_CYC without completion, the FSM goes to RELEASE with rsp_err=1.
REQ-034 Without APB_ARB_TIMEOUT_EN: no counter exists, and WAIT holds indefinitely.

Structure
REQ-035 The shared package apb_pkg holds ADDR_W/DATA_W defaults, the FSM state encoding (one-hot, 4 bits) and the requester-index type.
REQ-036 The sub-module apb_rr_pick (2-way round-robin selector: requests and priority in, grant index out) is the only child.

Verification
REQ-037 Reset, then req0 write with addr 0x005 and data 0xA5, PREADY=1 -> transfer high for ISSUE+WAIT, write_paddr=0x005, write_data=0xA5, ack=2'b01, rsp_err=0.
REQ-038 req1 read with addr 0x105, PREADY low for 3 cycles, bridge_rdata=0x3C -> ack=2'b10 and rsp_rdata=0x3C on the cycle after completion.
REQ-039 req0 and req1 asserted together twice -> grant order is 0,1,0,1 with no dropped ack.
REQ-040 PSLVERR pulsed in WAIT -> ack with rsp_err=1 and rsp_rdata=0; the next request proceeds normally.
REQ-041 With APB_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, PREADY held low -> ack with rsp_err=1 exactly 8 cycles after WAIT entry. Without the macro, no ack ever occurs.
REQ-042 PRESETn pulsed low in WAIT -> transfer=0 immediately (asynchronous), no ack, priority=requester 0.
